imem_arbiter: RTL and testbench

Shares one external instruction-memory read port among `NUM_CORES` fetch stages in the multi-core processor. Each core's fetch logic presents its PC as a read request. The arbiter picks one request round-robin, runs a single outstanding transaction on the IMEM port, and returns the instruction word with a one-cycle valid pulse to the owning core. It sits between the per-core fetch stages and the shared IMEM.

---
 rtl/imem_arbiter.sv | 136 +++++++++++++
 tb/tb_imem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one instruction-memory read port among NUM_CORES fetch stages.
// One outstanding transaction at a time; responses return as a one-cycle valid pulse.
module imem_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  output logic [NUM_CORES-1:0]        core_valid,
  output logic [DATA_W-1:0]           core_instr,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_ready,
  input  logic                        mem_rvalid,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int unsigned GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                 state, state_d;
  logic [GW-1:0]          last_grant, last_grant_d;
  logic [GW-1:0]          grant, grant_d;
  logic [GW-1:0]          pick;
  logic                   pick_found;
  logic [NUM_CORES-1:0]   eligible;
  logic [ADDR_W-1:0]      addr_arr [NUM_CORES];
  logic                   mem_req_d;
  logic [ADDR_W-1:0]      mem_addr_d;
  logic [NUM_CORES-1:0]   core_gnt_d;
  logic [NUM_CORES-1:0]   core_valid_d;
  logic [DATA_W-1:0]      core_instr_d;
  int unsigned            idx;
  logic [GW-1:0]          idx_g;

  // Unflatten per-core fetch addresses.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      addr_arr[i] = core_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Round-robin pick starting after last_grant; the core being answered this cycle is excluded.
  always_comb begin
    eligible   = core_req & ~core_valid;
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    idx_g      = '0;
    for (int unsigned k = 1; k <= NUM_CORES; k++) begin
      idx   = (32'(last_grant) + k) % NUM_CORES;
      idx_g = GW'(idx);
      if (!pick_found && eligible[idx_g]) begin
        pick       = idx_g;
        pick_found = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_CORES - 1);
      grant      <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      core_gnt   <= '0;
      core_valid <= '0;
      core_instr <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      grant      <= grant_d;
      mem_req    <= mem_req_d;
      mem_addr   <= mem_addr_d;
      core_gnt   <= core_gnt_d;
      core_valid <= core_valid_d;
      core_instr <= core_instr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (pick_found) state_d = ISSUE;
      ISSUE:   if (mem_ready)  state_d = WAIT;
      WAIT:    if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs.
  always_comb begin
    last_grant_d = last_grant;
    grant_d      = grant;
    mem_req_d    = mem_req;
    mem_addr_d   = mem_addr;
    core_gnt_d   = core_gnt;
    core_valid_d = '0;
    core_instr_d = core_instr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_d    = pick;
          mem_addr_d = addr_arr[pick];
          core_gnt_d = NUM_CORES'(1) << pick;
          mem_req_d  = 1'b1;
        end
      end
      ISSUE: begin
        if (mem_ready) mem_req_d = 1'b0;
      end
      WAIT: begin
        // A cancelled request still consumes its turn but gets no pulse.
        if (mem_rvalid) begin
          core_instr_d        = mem_rdata;
          core_valid_d[grant] = core_req[grant];
          last_grant_d        = grant;
          core_gnt_d          = '0;
        end
      end
      default: begin
        mem_req_d  = 1'b0;
        core_gnt_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter (4 cores, 32-bit address/data).
module tb_imem_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    core_req;
  logic [N*AW-1:0] core_addr;
  logic [N-1:0]    core_valid;
  logic [DW-1:0]   core_instr;
  logic [N-1:0]    core_gnt;
  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  imem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_addr  (core_addr),
    .core_valid (core_valid),
    .core_instr (core_instr),
    .core_gnt   (core_gnt),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return 32'h0000_1000 + 32'(i) * 32'h10;
  endfunction

  task automatic set_addrs();
    for (int i = 0; i < int'(N); i++) core_addr[i*AW +: AW] = addr_of(i);
  endtask

  task automatic quiet_inputs();
    core_req   = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    set_addrs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      core_req   = 4'($urandom);
      core_addr  = {$urandom(), $urandom(), $urandom(), $urandom()};
      mem_ready  = 1'($urandom);
      mem_rvalid = 1'($urandom);
      mem_rdata  = $urandom();
      tick();
    end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (core_valid !== 4'b0) begin n_bad++; $display("FAIL reset_core_valid: got %b want 0000", core_valid); end
    n_cmp++; if (core_gnt !== 4'b0) begin n_bad++; $display("FAIL reset_core_gnt: got %b want 0000", core_gnt); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (core_instr !== 32'h0) begin n_bad++; $display("FAIL reset_core_instr: got %h want 0", core_instr); end
    rst = 1'b1;
    set_addrs();
    core_req   = 4'b1111;
    mem_ready  = 1'b1;
    mem_rvalid = 1'b0;
    tick();
    n_cmp++; if (core_gnt !== 4'b0001) begin n_bad++; $display("FAIL reset_first_grant: got %b want 0001", core_gnt); end
    n_cmp++; if (mem_addr !== addr_of(0)) begin n_bad++; $display("FAIL reset_first_addr: got %h want %h", mem_addr, addr_of(0)); end
    core_req = '0;
    tick();
    mem_rvalid = 1'b1;
    tick();
    quiet_inputs();
  endtask

  task automatic test_single();
    do_reset();
    core_addr[2*AW +: AW] = 32'h0000_0040;
    core_req   = 4'b0100;
    mem_ready  = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0010_0093;
    tick();
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL single_mem_req: got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h40) begin n_bad++; $display("FAIL single_mem_addr: got %h want 00000040", mem_addr); end
    n_cmp++; if (core_gnt !== 4'b0100) begin n_bad++; $display("FAIL single_gnt: got %b want 0100", core_gnt); end
    n_cmp++; if (core_valid !== 4'b0000) begin n_bad++; $display("FAIL single_early_valid_c1: got %b want 0000", core_valid); end
    tick();
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL single_wait_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (core_valid !== 4'b0000) begin n_bad++; $display("FAIL single_early_valid_c2: got %b want 0000", core_valid); end
    tick();
    n_cmp++; if (core_valid !== 4'b0100) begin n_bad++; $display("FAIL single_valid: got %b want 0100", core_valid); end
    n_cmp++; if (core_instr !== 32'h0010_0093) begin n_bad++; $display("FAIL single_instr: got %h want 00100093", core_instr); end
    n_cmp++; if (core_gnt !== 4'b0000) begin n_bad++; $display("FAIL single_gnt_clear: got %b want 0000", core_gnt); end
    core_req = '0;
    tick();
    n_cmp++; if (core_valid !== 4'b0000) begin n_bad++; $display("FAIL single_pulse_width: got %b want 0000", core_valid); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL single_idle_mem_req: got %b want 0", mem_req); end
    quiet_inputs();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    do_reset();
    core_req   = 4'b1111;
    mem_ready  = 1'b1;
    mem_rvalid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp = 4'b0001 << (k % 4);
      tick();
      n_cmp++; if (core_gnt !== exp) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", k, core_gnt, exp); end
      n_cmp++; if (mem_addr !== addr_of(k % 4)) begin n_bad++; $display("FAIL rr_addr[%0d]: got %h want %h", k, mem_addr, addr_of(k % 4)); end
      tick();
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rr_wait_mem_req[%0d]: got %b want 0", k, mem_req); end
      mem_rdata = 32'hA000_0000 + 32'(k);
      tick();
      n_cmp++; if (core_valid !== exp) begin n_bad++; $display("FAIL rr_valid[%0d]: got %b want %b", k, core_valid, exp); end
      n_cmp++; if (core_instr !== 32'hA000_0000 + 32'(k)) begin n_bad++; $display("FAIL rr_instr[%0d]: got %h want %h", k, core_instr, 32'hA000_0000 + 32'(k)); end
      n_cmp++; if (core_gnt !== 4'b0000) begin n_bad++; $display("FAIL rr_gnt_clear[%0d]: got %b want 0000", k, core_gnt); end
    end
    quiet_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    core_addr[1*AW +: AW] = 32'h0000_0200;
    core_req = 4'b0010;
    tick();
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL bp_mem_req_start: got %b want 1", mem_req); end
    for (int c = 0; c < 5; c++) begin
      mem_rvalid = (c == 2);
      tick();
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL bp_mem_req_hold[%0d]: got %b want 1", c, mem_req); end
      n_cmp++; if (mem_addr !== 32'h200) begin n_bad++; $display("FAIL bp_mem_addr_hold[%0d]: got %h want 00000200", c, mem_addr); end
      n_cmp++; if (core_valid !== 4'b0000) begin n_bad++; $display("FAIL bp_issue_valid[%0d]: got %b want 0000", c, core_valid); end
    end
    mem_rvalid = 1'b0;
    mem_ready  = 1'b1;
    tick();
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL bp_mem_req_drop: got %b want 0", mem_req); end
    mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (core_valid !== 4'b0000) begin n_bad++; $display("FAIL bp_wait_valid[%0d]: got %b want 0000", c, core_valid); end
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    n_cmp++; if (core_valid !== 4'b0010) begin n_bad++; $display("FAIL bp_valid: got %b want 0010", core_valid); end
    n_cmp++; if (core_instr !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL bp_instr: got %h want deadbeef", core_instr); end
    mem_rvalid = 1'b0;
    core_req   = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (core_valid !== 4'b0000) begin n_bad++; $display("FAIL bp_extra_pulse[%0d]: got %b want 0000", c, core_valid); end
    end
    quiet_inputs();
  endtask

  task automatic test_cancel();
    do_reset();
    core_req  = 4'b0010;
    mem_ready = 1'b1;
    tick();
    n_cmp++; if (core_gnt !== 4'b0010) begin n_bad++; $display("FAIL cancel_gnt: got %b want 0010", core_gnt); end
    tick();
    core_req   = 4'b0000;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    tick();
    n_cmp++; if (core_valid !== 4'b0000) begin n_bad++; $display("FAIL cancel_valid: got %b want 0000", core_valid); end
    n_cmp++; if (core_gnt !== 4'b0000) begin n_bad++; $display("FAIL cancel_idle_gnt: got %b want 0000", core_gnt); end
    mem_rvalid = 1'b0;
    core_req   = 4'b1111;
    tick();
    n_cmp++; if (core_gnt !== 4'b0100) begin n_bad++; $display("FAIL cancel_next_grant: got %b want 0100", core_gnt); end
    quiet_inputs();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    core_req  = 4'b0001;
    mem_ready = 1'b1;
    tick();
    tick();
    n_cmp++; if (core_gnt !== 4'b0001) begin n_bad++; $display("FAIL rmw_wait_gnt: got %b want 0001", core_gnt); end
    core_req  = '0;
    mem_ready = 1'b0;
    rst       = 1'b0;
    tick();
    rst        = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    tick();
    n_cmp++; if (core_valid !== 4'b0000) begin n_bad++; $display("FAIL rmw_valid: got %b want 0000", core_valid); end
    n_cmp++; if (core_gnt !== 4'b0000) begin n_bad++; $display("FAIL rmw_gnt: got %b want 0000", core_gnt); end
    n_cmp++; if (core_instr !== 32'h0) begin n_bad++; $display("FAIL rmw_instr: got %h want 0", core_instr); end
    mem_rvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rmw_mem_req_idle[%0d]: got %b want 0", c, mem_req); end
    end
    core_req = 4'b0001;
    tick();
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rmw_new_req: got %b want 1", mem_req); end
    n_cmp++; if (core_gnt !== 4'b0001) begin n_bad++; $display("FAIL rmw_new_gnt: got %b want 0001", core_gnt); end
    quiet_inputs();
  endtask

  initial begin
    rst       = 1'b0;
    core_addr = '0;
    quiet_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_cancel();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
